// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_INSTR_W = 32;
   localparam int DEF_TAG_W   = 8;
   localparam int PC_INC      = 4;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetcher: requests at PC, pushes {instr, tag}
// into the downstream FIFO, parks a word while the FIFO is full, drains on redirect.
//
// state | meaning
// REQ   | request driven at PC, waiting for grant
// WAIT  | request granted, waiting for response
// HOLD  | response parked in hold register, waiting for FIFO space
// DRAIN | granted request was redirected away, swallow its response
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = DEF_ADDR_W,
   parameter int unsigned       INSTR_W  = DEF_INSTR_W,
   parameter int unsigned       TAG_W    = DEF_TAG_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_redirect,
   input  logic [ADDR_W-1:0]  i_redirect_pc,
   output logic               o_imem_req,
   output logic [ADDR_W-1:0]  o_imem_addr,
   input  logic               i_imem_gnt,
   input  logic               i_imem_rvalid,
   input  logic [INSTR_W-1:0] i_imem_rdata,
   output logic               o_WrtEn,
   output logic [INSTR_W-1:0] o_data0,
   output logic [TAG_W-1:0]   o_data1,
   input  logic               i_Full
);

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [TAG_W-1:0]   seq_q, seq_d;
   logic [INSTR_W-1:0] hold_q, hold_d;
   logic               push;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      seq_d   = seq_q;
      hold_d  = hold_q;
      push    = 1'b0;
      if (i_redirect) begin
         // Redirect wins over everything; a granted-but-unanswered request must be drained.
         pc_d = i_redirect_pc;
         case (state_q)
            REQ:     state_d = i_imem_gnt ? DRAIN : REQ;
            WAIT:    state_d = i_imem_rvalid ? REQ : DRAIN;
            HOLD:    state_d = REQ;
            DRAIN:   state_d = i_imem_rvalid ? REQ : DRAIN;
            default: state_d = REQ;
         endcase
      end else begin
         case (state_q)
            REQ: begin
               if (i_imem_gnt) state_d = WAIT;
            end
            WAIT: begin
               if (i_imem_rvalid) begin
                  if (i_Full) begin
                     hold_d  = i_imem_rdata;
                     state_d = HOLD;
                  end else begin
                     push = 1'b1;
                  end
               end
            end
            HOLD: begin
               if (!i_Full) push = 1'b1;
            end
            DRAIN: begin
               if (i_imem_rvalid) state_d = REQ;
            end
            default: state_d = REQ;
         endcase
         if (push) begin
            pc_d    = pc_q + ADDR_W'(PC_INC);
            seq_d   = seq_q + TAG_W'(1);
            state_d = REQ;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= REQ;
         pc_q    <= RESET_PC;
         seq_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         seq_q   <= seq_d;
         hold_q  <= hold_d;
      end
   end

   // Push must land in the rvalid cycle, so the FIFO strobe is combinational.
   assign o_imem_req  = !rst && (state_q == REQ);
   assign o_imem_addr = rst ? RESET_PC : pc_q;
   assign o_WrtEn     = !rst && push;
   assign o_data0     = o_WrtEn ? ((state_q == HOLD) ? hold_q : i_imem_rdata) : '0;
   assign o_data1     = o_WrtEn ? seq_q : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a per-cycle outstanding/held-word model.
`timescale 1ns/1ps
module tb_instr_fetch;

   localparam int AW = 32;
   localparam int IW = 32;
   localparam int TW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, redirect, gnt, rvalid, full;
   logic [AW-1:0] redirect_pc, imem_addr;
   logic          imem_req, wrten;
   logic [IW-1:0] rdata, data0;
   logic [TW-1:0] data1;

   logic          rst2, redirect2, gnt2, rvalid2, full2;
   logic [AW-1:0] redirect_pc2, imem_addr2;
   logic          imem_req2, wrten2;
   logic [IW-1:0] rdata2, data0_2;
   logic [TW-1:0] data1_2;

   instr_fetch #(.ADDR_W(AW), .INSTR_W(IW), .TAG_W(TW), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
      .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_gnt(gnt),
      .i_imem_rvalid(rvalid), .i_imem_rdata(rdata), .o_WrtEn(wrten),
      .o_data0(data0), .o_data1(data1), .i_Full(full));

   instr_fetch #(.ADDR_W(AW), .INSTR_W(IW), .TAG_W(TW), .RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .rst(rst2), .i_redirect(redirect2), .i_redirect_pc(redirect_pc2),
      .o_imem_req(imem_req2), .o_imem_addr(imem_addr2), .i_imem_gnt(gnt2),
      .i_imem_rvalid(rvalid2), .i_imem_rdata(rdata2), .o_WrtEn(wrten2),
      .o_data0(data0_2), .o_data1(data1_2), .i_Full(full2));

   int checks = 0;
   int failures = 0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // memory responder for dut: one outstanding response, configurable latency
   int          lat_cfg = 1;
   int          resp_cnt = 0;
   logic [31:0] resp_addr = '0;
   initial begin
      rvalid = 1'b0;
      rdata  = '0;
      forever begin
         @(negedge clk);
         if (imem_req && gnt) begin
            resp_cnt  = lat_cfg;
            resp_addr = imem_addr;
         end
         @(posedge clk);
         #1;
         rvalid = 1'b0;
         rdata  = '0;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               rvalid = 1'b1;
               rdata  = mem(resp_addr);
            end
         end
      end
   end

   typedef struct {
      logic [31:0] data;
      logic [7:0]  tag;
      int          cyc;
   } push_t;

   push_t       push_log[$];
   logic [31:0] req_log[$];
   int          cyc_cnt = 0;

   // model: expected PC/tag, one outstanding request (live or stale), one held word
   logic [31:0] m_pc = '0, m_out_addr = '0, m_held_data = '0;
   logic [7:0]  m_tag = '0;
   bit          m_busy = 0, m_live = 0, m_held = 0;

   always @(negedge clk) begin
      bit exp_req, exp_push;
      logic [31:0] exp_data;
      if (rst) begin
         chk("rst_req",   64'(imem_req), 64'(0));
         chk("rst_wrten", 64'(wrten), 64'(0));
         chk("rst_data0", 64'(data0), 64'(0));
         chk("rst_data1", 64'(data1), 64'(0));
         chk("rst_addr",  64'(imem_addr), 64'(32'h0));
         m_pc = '0; m_tag = '0; m_busy = 0; m_live = 0; m_held = 0;
         cyc_cnt = 0;
      end else begin
         exp_req = !m_busy && !m_held;
         chk("req", 64'(imem_req), 64'(exp_req));
         if (exp_req) chk("addr", 64'(imem_addr), 64'(m_pc));
         exp_push = (m_held || (m_busy && m_live && rvalid)) && !full && !redirect;
         chk("wrten", 64'(wrten), 64'(exp_push));
         if (exp_push) begin
            exp_data = m_held ? m_held_data : mem(m_out_addr);
            chk("data0", 64'(data0), 64'(exp_data));
            chk("data1", 64'(data1), 64'(m_tag));
         end
         if (wrten) push_log.push_back('{data0, data1, cyc_cnt});
         if (imem_req && gnt) req_log.push_back(imem_addr);

         if (redirect) begin
            m_pc   = redirect_pc;
            m_held = 0;
            if (m_busy) begin
               if (rvalid) m_busy = 0;
               else        m_live = 0;
            end else if (exp_req && gnt) begin
               m_busy = 1;
               m_live = 0;
            end
         end else if (exp_push) begin
            m_pc   = m_pc + 32'd4;
            m_tag  = m_tag + 8'd1;
            m_held = 0;
            m_busy = 0;
         end else if (m_busy && rvalid) begin
            if (m_live) begin
               m_held      = 1;
               m_held_data = mem(m_out_addr);
            end
            m_busy = 0;
         end else if (exp_req && gnt) begin
            m_busy     = 1;
            m_live     = 1;
            m_out_addr = m_pc;
         end
         cyc_cnt++;
      end
   end

   // second instance: RESET_PC at top of address space, 1-cycle memory
   logic [31:0] req_log2[$];
   logic [7:0]  tag_log2[$];
   logic [31:0] dat_log2[$];
   initial begin
      bit          hs;
      logic [31:0] a;
      rst2 = 1'b1; redirect2 = 1'b0; redirect_pc2 = '0; gnt2 = 1'b1; full2 = 1'b0;
      rvalid2 = 1'b0; rdata2 = '0;
      repeat (3) @(posedge clk);
      #1 rst2 = 1'b0;
      forever begin
         @(negedge clk);
         hs = imem_req2 && gnt2;
         a  = imem_addr2;
         if (hs) req_log2.push_back(a);
         if (wrten2) begin
            tag_log2.push_back(data1_2);
            dat_log2.push_back(data0_2);
         end
         @(posedge clk);
         #1;
         rvalid2 = hs;
         rdata2  = hs ? mem(a) : '0;
      end
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic at_cycle(input int n);
      int guard = 0;
      do begin
         @(posedge clk);
         guard++;
      end while (cyc_cnt != n && guard < 1000);
      #1;
      if (cyc_cnt != n) begin
         checks++;
         failures++;
         $display("FAIL at_cycle reached=%0d required=%0d", cyc_cnt, n);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      int n;
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; gnt = 1'b1; full = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // streaming, then FIFO full for 3 cycles on the response for 0x8
      at_cycle(5);  full = 1'b1;
      at_cycle(8);  full = 1'b0; lat_cfg = 3;
      at_cycle(9);
      chk("n_push_after_hold", 64'(push_log.size()), 64'(3));
      if (push_log.size() >= 3) begin
         chk("p0_data", 64'(push_log[0].data), 64'(32'hC0DE_0000));
         chk("p0_tag",  64'(push_log[0].tag), 64'(0));
         chk("p0_cyc",  64'(push_log[0].cyc), 64'(1));
         chk("p1_data", 64'(push_log[1].data), 64'(32'hC0DE_0004));
         chk("p1_tag",  64'(push_log[1].tag), 64'(1));
         chk("p1_cyc",  64'(push_log[1].cyc), 64'(3));
         chk("p2_data", 64'(push_log[2].data), 64'(32'hC0DE_0008));
         chk("p2_tag",  64'(push_log[2].tag), 64'(2));
         chk("p2_cyc",  64'(push_log[2].cyc), 64'(8));
      end
      if (req_log.size() >= 3) begin
         chk("r0", 64'(req_log[0]), 64'(32'h0));
         chk("r1", 64'(req_log[1]), 64'(32'h4));
         chk("r2", 64'(req_log[2]), 64'(32'h8));
      end else chk("n_req_early", 64'(req_log.size()), 64'(3));

      // redirect to 0x100 while waiting; stale response arrives two cycles later
      at_cycle(10); redirect = 1'b1; redirect_pc = 32'h100;
      at_cycle(11); redirect = 1'b0;
      at_cycle(12); lat_cfg = 1;
      at_cycle(14);
      chk("stale_not_pushed", 64'(push_log.size()), 64'(3));
      chk("n_req_redir", 64'(req_log.size()), 64'(5));
      if (req_log.size() >= 5) chk("r_after_redir", 64'(req_log[4]), 64'(32'h100));

      // redirect to 0x200 coincident with rvalid of 0x104
      at_cycle(16); redirect = 1'b1; redirect_pc = 32'h200;
      at_cycle(17); redirect = 1'b0;
      chk("addr_0x200", 64'(imem_addr), 64'(32'h200));
      chk("n_push_coinc", 64'(push_log.size()), 64'(4));
      if (push_log.size() >= 4) chk("p3_data", 64'(push_log[3].data), 64'(32'hC0DE_0100));

      // redirect in REQ without grant, then with grant
      at_cycle(19); gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
      at_cycle(20); redirect = 1'b0;
      chk("req_0x300", 64'(imem_req), 64'(1));
      chk("addr_0x300", 64'(imem_addr), 64'(32'h300));
      gnt = 1'b1;
      at_cycle(22); redirect = 1'b1; redirect_pc = 32'h400;
      at_cycle(23); redirect = 1'b0;
      at_cycle(26);
      chk("n_push_req_redir", 64'(push_log.size()), 64'(7));
      if (push_log.size() >= 7) begin
         chk("p5_data", 64'(push_log[5].data), 64'(32'hC0DE_0300));
         chk("p6_data", 64'(push_log[6].data), 64'(32'hC0DE_0400));
         chk("p6_tag",  64'(push_log[6].tag), 64'(6));
         chk("p6_cyc",  64'(push_log[6].cyc), 64'(25));
      end

      // random FIFO backpressure, then run past the tag wrap
      for (int i = 0; i < 600; i++) begin
         next_cyc();
         full = ($urandom_range(0, 3) == 0);
      end
      full = 1'b0;
      guard = 0;
      while (push_log.size() < 260 && guard < 3000) begin
         next_cyc();
         guard++;
      end
      chk("tag_wrap_reached", 64'(push_log.size() >= 260), 64'(1));
      if (push_log.size() >= 260) begin
         chk("tag255", 64'(push_log[255].tag), 64'(255));
         chk("tag256", 64'(push_log[256].tag), 64'(0));
      end

      // reset while waiting; late response must not push
      lat_cfg = 4;
      next_cyc();
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!(imem_req && gnt) && guard < 50);
      chk("found_handshake", 64'(imem_req && gnt), 64'(1));
      next_cyc();
      rst = 1'b1; gnt = 1'b0;
      n = push_log.size();
      next_cyc();
      chk("rstw_req",  64'(imem_req), 64'(0));
      chk("rstw_addr", 64'(imem_addr), 64'(32'h0));
      next_cyc();
      rst = 1'b0;
      next_cyc();
      next_cyc();
      chk("late_rvalid_no_push", 64'(push_log.size()), 64'(n));
      lat_cfg = 1;
      gnt = 1'b1;
      repeat (3) next_cyc();
      chk("post_rst_push_cnt", 64'(push_log.size()), 64'(n + 1));
      if (push_log.size() > n) begin
         chk("post_rst_tag",  64'(push_log[n].tag), 64'(0));
         chk("post_rst_data", 64'(push_log[n].data), 64'(32'hC0DE_0000));
      end

      // second instance: PC wrap from 0xFFFF_FFFC
      chk("d2_nreq", 64'(req_log2.size() >= 2), 64'(1));
      if (req_log2.size() >= 2) begin
         chk("d2_addr0", 64'(req_log2[0]), 64'(32'hFFFF_FFFC));
         chk("d2_addr1", 64'(req_log2[1]), 64'(32'h0));
      end
      chk("d2_npush", 64'(tag_log2.size() >= 2), 64'(1));
      if (tag_log2.size() >= 2) begin
         chk("d2_tag0",  64'(tag_log2[0]), 64'(0));
         chk("d2_data0", 64'(dat_log2[0]), 64'(32'h3F21_FFFC));
         chk("d2_tag1",  64'(tag_log2[1]), 64'(1));
         chk("d2_data1", 64'(dat_log2[1]), 64'(32'hC0DE_0000));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
